// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if -- signal bundle between the control unit and the
// next-microaddress generator.
//
//   conditional_wires : condition bus from the status storage stage
//                       (bit0 = 1, bits 2k+1/2k+2 = flag k / ~flag k)
//   seq_op            : sequencing op of the current microinstruction
//   cond_sel          : index into conditional_wires (9..15 read as 0)
//   branch_addr       : JUMP/CALL target
//   dispatch_addr     : opcode-decoded entry address
//   hold              : stall, freezes every piece of sequencer state
//   upc               : registered micro-PC
//   branch_taken      : last update was a taken JUMP or CALL
//   stack_depth       : return-stack occupancy
//   stack_overflow    : sticky, a taken CALL found the stack full
//   stack_underflow   : sticky, a RET found the stack empty
//
// Handshake: there is no valid/ready pair. The sequencer consumes one op on
// every rising edge where hold is low; with hold high the op is ignored and
// all outputs keep their values.
//
// Modports: master = control-unit side driving the op, slave = sequencer.

interface micro_sequencer_if #(
  parameter int UADDR_W     = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic [8:0]         conditional_wires;
  logic [2:0]         seq_op;
  logic [3:0]         cond_sel;
  logic [UADDR_W-1:0] branch_addr;
  logic [UADDR_W-1:0] dispatch_addr;
  logic               hold;
  logic [UADDR_W-1:0] upc;
  logic               branch_taken;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_overflow;
  logic               stack_underflow;

  modport master (
    output conditional_wires, seq_op, cond_sel, branch_addr, dispatch_addr, hold,
    input  upc, branch_taken, stack_depth, stack_overflow, stack_underflow
  );

  modport slave (
    input  conditional_wires, seq_op, cond_sel, branch_addr, dispatch_addr, hold,
    output upc, branch_taken, stack_depth, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer -- next-microaddress generator for the multi-cycle CPU
// control unit. Each cycle it selects one condition from the status bus,
// evaluates the sequencing op and registers the next micro-PC. A small
// return-address stack supports microsubroutines.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; wins over hold and every op
//   bus   : micro_sequencer_if.slave (op inputs in, micro-PC/status out)
//
// Ops: 000 NEXT, 001 JUMP, 010 CALL, 011 RET, 100 DISPATCH, 101 RESTART,
// 110/111 behave as NEXT.

module micro_sequencer #(
  parameter int                 UADDR_W     = 8,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [UADDR_W-1:0] RESET_ADDR  = '0
) (
  input logic                clk,
  input logic                reset,
  micro_sequencer_if.slave   bus
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  localparam logic [2:0] OP_NEXT     = 3'b000;
  localparam logic [2:0] OP_JUMP     = 3'b001;
  localparam logic [2:0] OP_CALL     = 3'b010;
  localparam logic [2:0] OP_RET      = 3'b011;
  localparam logic [2:0] OP_DISPATCH = 3'b100;
  localparam logic [2:0] OP_RESTART  = 3'b101;

  logic [UADDR_W-1:0] upc_q;
  logic               branch_taken_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               overflow_q;
  logic               underflow_q;
  logic [UADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [15:0]        cond_bus;
  logic               cond;
  logic [UADDR_W-1:0] incr;
  logic               stack_full;
  logic               stack_empty;
  logic [PTR_W-1:0]   push_idx;
  logic [PTR_W-1:0]   top_idx;
  logic               push_en;

  // Widening the bus to 16 bits makes cond_sel 9..15 read as 0 without a
  // separate range check.
  assign cond_bus    = {7'b0, bus.conditional_wires};
  assign cond        = cond_bus[bus.cond_sel];
  assign incr        = upc_q + {{(UADDR_W-1){1'b0}}, 1'b1};
  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  assign push_idx    = depth_q[PTR_W-1:0];
  assign top_idx     = depth_q[PTR_W-1:0] - PTR_W'(1);

  // A taken CALL on a full stack still jumps but must not write an entry.
  assign push_en = !reset && !bus.hold && (bus.seq_op == OP_CALL) && cond && !stack_full;

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= incr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q          <= RESET_ADDR;
      branch_taken_q <= 1'b0;
      depth_q        <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else if (!bus.hold) begin
      branch_taken_q <= 1'b0;
      case (bus.seq_op)
        OP_JUMP: begin
          if (cond) begin
            upc_q          <= bus.branch_addr;
            branch_taken_q <= 1'b1;
          end else begin
            upc_q <= incr;
          end
        end
        OP_CALL: begin
          if (cond) begin
            upc_q          <= bus.branch_addr;
            branch_taken_q <= 1'b1;
            if (stack_full) begin
              overflow_q <= 1'b1;
            end else begin
              depth_q <= depth_q + DEPTH_W'(1);
            end
          end else begin
            upc_q <= incr;
          end
        end
        OP_RET: begin
          if (!stack_empty) begin
            upc_q   <= stack_mem[top_idx];
            depth_q <= depth_q - DEPTH_W'(1);
          end else begin
            upc_q       <= incr;
            underflow_q <= 1'b1;
          end
        end
        OP_DISPATCH: upc_q <= bus.dispatch_addr;
        // Error flags deliberately survive RESTART; only reset clears them.
        OP_RESTART: begin
          upc_q   <= RESET_ADDR;
          depth_q <= '0;
        end
        OP_NEXT:  upc_q <= incr;
        default:  upc_q <= incr;
      endcase
    end
  end

  assign bus.upc             = upc_q;
  assign bus.branch_taken    = branch_taken_q;
  assign bus.stack_depth     = depth_q;
  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (stack overflow/underflow, hold).
// Expected outputs are pushed to a queue when an op is driven and popped
// when the DUT output is sampled one edge later.

module tb_micro_sequencer;

  localparam logic [2:0] OP_NEXT     = 3'b000;
  localparam logic [2:0] OP_JUMP     = 3'b001;
  localparam logic [2:0] OP_CALL     = 3'b010;
  localparam logic [2:0] OP_RET      = 3'b011;
  localparam logic [2:0] OP_DISPATCH = 3'b100;
  localparam logic [2:0] OP_RESTART  = 3'b101;
  localparam logic [2:0] OP_RSV6     = 3'b110;
  localparam logic [2:0] OP_RSV7     = 3'b111;

  localparam logic [8:0] CW_A   = 9'b000000011; // flag0=1, ~flag0=0
  localparam logic [8:0] CW_ALL = 9'b111111111;
  localparam logic [8:0] CW_B8  = 9'b100000000;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] op;
    logic [3:0] sel;
    logic [8:0] cw;
    logic [7:0] br;
    logic [7:0] disp;
    logic       hold;
    logic [7:0] e_upc;
    logic       e_bt;
    logic [2:0] e_depth;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  logic clk;
  logic reset;

  micro_sequencer_if #(.UADDR_W(8), .STACK_DEPTH(4)) bus ();

  micro_sequencer #(.UADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      $display("FAIL %s.%s: got %h expected %h", name, field, act, expv);
    end else begin
      passed++;
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic [2:0] op,
                              input logic [3:0] sel, input logic [8:0] cw,
                              input logic [7:0] br, input logic [7:0] disp,
                              input logic hold, input logic [7:0] e_upc,
                              input logic e_bt, input logic [2:0] e_depth,
                              input logic e_ovf, input logic e_unf);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.sel = sel; v.cw = cw;
    v.br = br; v.disp = disp; v.hold = hold; v.e_upc = e_upc; v.e_bt = e_bt;
    v.e_depth = e_depth; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run(input vec_t v);
    logic [13:0] e;
    reset                 = v.rst;
    bus.seq_op            = v.op;
    bus.cond_sel          = v.sel;
    bus.conditional_wires = v.cw;
    bus.branch_addr       = v.br;
    bus.dispatch_addr     = v.disp;
    bus.hold              = v.hold;
    exp_q.push_back({v.e_upc, v.e_bt, v.e_depth, v.e_ovf, v.e_unf});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(v.name, "upc",       bus.upc,                   e[13:6]);
    check(v.name, "taken",     {7'b0, bus.branch_taken},  {7'b0, e[5]});
    check(v.name, "depth",     {5'b0, bus.stack_depth},   {5'b0, e[4:2]});
    check(v.name, "overflow",  {7'b0, bus.stack_overflow},  {7'b0, e[1]});
    check(v.name, "underflow", {7'b0, bus.stack_underflow}, {7'b0, e[0]});
  endtask

  vec_t vq[$];

  initial begin
    reset = 1'b1;
    bus.seq_op = OP_NEXT;
    bus.cond_sel = 4'd0;
    bus.conditional_wires = CW_A;
    bus.branch_addr = 8'h00;
    bus.dispatch_addr = 8'h00;
    bus.hold = 1'b0;

    // ---- vector table: name rst op sel cw br disp hold | upc bt depth ovf unf
    vq.push_back(mk("rst",        1, OP_NEXT,     0,  CW_A,   8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk("next1",      0, OP_NEXT,     0,  CW_A,   8'h00, 8'h00, 0, 8'h01, 0, 0, 0, 0));
    vq.push_back(mk("next2",      0, OP_NEXT,     0,  CW_A,   8'h00, 8'h00, 0, 8'h02, 0, 0, 0, 0));
    vq.push_back(mk("next3",      0, OP_NEXT,     0,  CW_A,   8'h00, 8'h00, 0, 8'h03, 0, 0, 0, 0));
    vq.push_back(mk("rst_jump",   1, OP_JUMP,     0,  CW_A,   8'h55, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk("go_10",      0, OP_JUMP,     0,  CW_A,   8'h10, 8'h00, 0, 8'h10, 1, 0, 0, 0));
    vq.push_back(mk("jump_flag",  0, OP_JUMP,     1,  CW_A,   8'h40, 8'h00, 0, 8'h40, 1, 0, 0, 0));
    vq.push_back(mk("go_10b",     0, OP_JUMP,     0,  CW_A,   8'h10, 8'h00, 0, 8'h10, 1, 0, 0, 0));
    vq.push_back(mk("jump_nflag", 0, OP_JUMP,     2,  CW_A,   8'h40, 8'h00, 0, 8'h11, 0, 0, 0, 0));
    vq.push_back(mk("jump_sel12", 0, OP_JUMP,     12, CW_ALL, 8'h40, 8'h00, 0, 8'h12, 0, 0, 0, 0));
    vq.push_back(mk("jump_sel8",  0, OP_JUMP,     8,  CW_B8,  8'h77, 8'h00, 0, 8'h77, 1, 0, 0, 0));
    vq.push_back(mk("jump_sel9",  0, OP_JUMP,     9,  CW_ALL, 8'h40, 8'h00, 0, 8'h78, 0, 0, 0, 0));
    vq.push_back(mk("rsv6",       0, OP_RSV6,     0,  CW_A,   8'h40, 8'h40, 0, 8'h79, 0, 0, 0, 0));
    vq.push_back(mk("rsv7",       0, OP_RSV7,     0,  CW_A,   8'h40, 8'h40, 0, 8'h7A, 0, 0, 0, 0));
    vq.push_back(mk("go_05",      0, OP_JUMP,     0,  CW_A,   8'h05, 8'h00, 0, 8'h05, 1, 0, 0, 0));
    vq.push_back(mk("call_20",    0, OP_CALL,     0,  CW_A,   8'h20, 8'h00, 0, 8'h20, 1, 1, 0, 0));
    vq.push_back(mk("sub_next",   0, OP_NEXT,     0,  CW_A,   8'h00, 8'h00, 0, 8'h21, 0, 1, 0, 0));
    vq.push_back(mk("call_30",    0, OP_CALL,     0,  CW_A,   8'h30, 8'h00, 0, 8'h30, 1, 2, 0, 0));
    vq.push_back(mk("call_nt",    0, OP_CALL,     2,  CW_A,   8'h99, 8'h00, 0, 8'h31, 0, 2, 0, 0));
    vq.push_back(mk("ret_22",     0, OP_RET,      0,  CW_A,   8'h00, 8'h00, 0, 8'h22, 0, 1, 0, 0));
    vq.push_back(mk("ret_06",     0, OP_RET,      2,  CW_A,   8'h00, 8'h00, 0, 8'h06, 0, 0, 0, 0));
    vq.push_back(mk("go_ff",      0, OP_JUMP,     0,  CW_A,   8'hFF, 8'h00, 0, 8'hFF, 1, 0, 0, 0));
    vq.push_back(mk("wrap",       0, OP_NEXT,     0,  CW_A,   8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk("dispatch",   0, OP_DISPATCH, 9,  CW_A,   8'h11, 8'h80, 0, 8'h80, 0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      run(vq[i]);
    end

    // ---- overflow / underflow / RESTART persistence (starts at 0x80, empty)
    run(mk("ov_call1",  0, OP_CALL,    0, CW_A, 8'h10, 8'h00, 0, 8'h10, 1, 1, 0, 0));
    run(mk("ov_call2",  0, OP_CALL,    0, CW_A, 8'h20, 8'h00, 0, 8'h20, 1, 2, 0, 0));
    run(mk("ov_call3",  0, OP_CALL,    0, CW_A, 8'h30, 8'h00, 0, 8'h30, 1, 3, 0, 0));
    run(mk("ov_call4",  0, OP_CALL,    0, CW_A, 8'h40, 8'h00, 0, 8'h40, 1, 4, 0, 0));
    run(mk("ov_call5",  0, OP_CALL,    0, CW_A, 8'h50, 8'h00, 0, 8'h50, 1, 4, 1, 0));
    run(mk("ov_ret1",   0, OP_RET,     0, CW_A, 8'h00, 8'h00, 0, 8'h31, 0, 3, 1, 0));
    run(mk("ov_ret2",   0, OP_RET,     0, CW_A, 8'h00, 8'h00, 0, 8'h21, 0, 2, 1, 0));
    run(mk("ov_ret3",   0, OP_RET,     0, CW_A, 8'h00, 8'h00, 0, 8'h11, 0, 1, 1, 0));
    run(mk("ov_ret4",   0, OP_RET,     0, CW_A, 8'h00, 8'h00, 0, 8'h81, 0, 0, 1, 0));
    run(mk("un_ret5",   0, OP_RET,     0, CW_A, 8'h00, 8'h00, 0, 8'h82, 0, 0, 1, 1));
    run(mk("pre_rs",    0, OP_CALL,    0, CW_A, 8'h60, 8'h00, 0, 8'h60, 1, 1, 1, 1));
    run(mk("restart",   0, OP_RESTART, 0, CW_A, 8'h60, 8'h00, 0, 8'h00, 0, 0, 1, 1));
    run(mk("post_rs",   0, OP_NEXT,    0, CW_A, 8'h00, 8'h00, 0, 8'h01, 0, 0, 1, 1));
    run(mk("rst_hold",  1, OP_JUMP,    0, CW_A, 8'h33, 8'h00, 1, 8'h00, 0, 0, 0, 0));

    // ---- hold during CALL, then release
    run(mk("h_go05",    0, OP_JUMP,    0, CW_A, 8'h05, 8'h00, 0, 8'h05, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      run(mk("h_call",  0, OP_CALL,    0, CW_A, 8'h20, 8'h00, 1, 8'h05, 1, 0, 0, 0));
    end
    run(mk("h_release", 0, OP_CALL,    0, CW_A, 8'h20, 8'h00, 0, 8'h20, 1, 1, 0, 0));
    run(mk("h_next",    0, OP_NEXT,    0, CW_A, 8'h00, 8'h00, 0, 8'h21, 0, 1, 0, 0));
    run(mk("h_ret",     0, OP_RET,     0, CW_A, 8'h00, 8'h00, 0, 8'h06, 0, 0, 0, 0));
    run(mk("h_ret_hld", 0, OP_RET,     0, CW_A, 8'h00, 8'h00, 1, 8'h06, 0, 0, 0, 0));
    run(mk("h_ret_unf", 0, OP_RET,     0, CW_A, 8'h00, 8'h00, 0, 8'h07, 0, 0, 0, 1));

    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end else begin
      passed++;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
